pwm_sample_decoder: RTL and testbench

//  Receive side of the audio PWM link: recovers 8-bit audio samples from a PWM waveform
//  of the form pwm = (cnt < sample), with cnt free-running 0..2^SAMPLE_W-1 on tick_en.

---
 rtl/pwm_sample_decoder_if.sv | 29 ++
 rtl/pwm_sample_decoder.sv | 141 ++++++++++++++
 tb/tb_pwm_sample_decoder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_sample_decoder_if.sv
// rtl/pwm_sample_decoder_if.sv - PWM link receive-side signal bundle
interface pwm_sample_decoder_if #(
    parameter int SAMPLE_W = 8
);
    logic                tick_en;
    logic                pwm_in;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic                locked;
    logic                err;

    modport master (
        output tick_en,
        output pwm_in,
        input  sample_out,
        input  sample_valid,
        input  locked,
        input  err
    );

    modport slave (
        input  tick_en,
        input  pwm_in,
        output sample_out,
        output sample_valid,
        output locked,
        output err
    );
endinterface

// File: rtl/pwm_sample_decoder.sv
// rtl/pwm_sample_decoder.sv - PWM frame aligner and sample recovery, optional PWM_DEC_FILTER_EN glitch filter
module pwm_sample_decoder #(
    parameter int SAMPLE_W     = 8,
    parameter int LOCK_PERIODS = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_sample_decoder_if.slave dec
);
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [3:0] GOOD_LAST = 4'(LOCK_PERIODS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s;
    logic                   lvl;
    logic                   lvl_q;
    logic                   rise;
    logic                   phase_end;
    logic [SAMPLE_W-1:0]    phase;
    logic [SAMPLE_W:0]      hi_cnt;
    logic [SAMPLE_W:0]      total;
    logic [SAMPLE_W:0]      hi_next;
    logic [SAMPLE_W-1:0]    captured;
    logic [3:0]             good;
    state_t                 state;

    // Bring the asynchronous PWM line into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], dec.pwm_in};
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEC_FILTER_EN
    logic [1:0] taps;

    // Keep the two previous tick samples for the 3-tap majority vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (dec.tick_en) begin
            taps <= {taps[0], pwm_s};
        end
    end

    assign lvl = (pwm_s & taps[0]) | (pwm_s & taps[1]) | (taps[0] & taps[1]);
`else
    assign lvl = pwm_s;
`endif

    // Level seen at the previous tick, so edges are measured tick to tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= 1'b0;
        end else if (dec.tick_en) begin
            lvl_q <= lvl;
        end
    end

    assign rise      = lvl & ~lvl_q;
    assign phase_end = &phase;
    assign total     = hi_cnt + {{SAMPLE_W{1'b0}}, lvl};
    assign captured  = total[SAMPLE_W] ? {SAMPLE_W{1'b1}} : total[SAMPLE_W-1:0];
    assign hi_next   = phase_end ? '0 : total;

    // Framing FSM: hunt for an edge, confirm alignment, then emit one sample per period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= HUNT;
            phase            <= '0;
            hi_cnt           <= '0;
            good             <= '0;
            dec.sample_out   <= '0;
            dec.sample_valid <= 1'b0;
            dec.locked       <= 1'b0;
            dec.err          <= 1'b0;
        end else begin
            dec.sample_valid <= 1'b0;
            dec.err          <= 1'b0;
            if (dec.tick_en) begin
                case (state)
                    HUNT: begin
                        if (rise) begin
                            phase  <= SAMPLE_W'(1);
                            hi_cnt <= (SAMPLE_W+1)'(1);
                            good   <= '0;
                            state  <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (rise && phase != '0) begin
                            phase  <= SAMPLE_W'(1);
                            hi_cnt <= (SAMPLE_W+1)'(1);
                            good   <= '0;
                        end else begin
                            phase  <= phase + 1'b1;
                            hi_cnt <= hi_next;
                            if (rise) begin
                                good <= good + 1'b1;
                                if (good == GOOD_LAST) begin
                                    state      <= LOCK;
                                    dec.locked <= 1'b1;
                                end
                            end
                        end
                    end
                    LOCK: begin
                        if (rise && phase != '0) begin
                            dec.err    <= 1'b1;
                            dec.locked <= 1'b0;
                            phase      <= SAMPLE_W'(1);
                            hi_cnt     <= (SAMPLE_W+1)'(1);
                            good       <= '0;
                            state      <= SYNC;
                        end else begin
                            phase  <= phase + 1'b1;
                            hi_cnt <= hi_next;
                            if (phase_end) begin
                                dec.sample_out   <= captured;
                                dec.sample_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_sample_decoder.sv
// tb/tb_pwm_sample_decoder.sv - randomized bench for pwm_sample_decoder with period-level reference model
module tb_pwm_sample_decoder;
    localparam int LP = 4;
`ifdef PWM_DEC_FILTER_EN
    localparam int DLY = 1;
    localparam bit FILTER = 1'b1;
`else
    localparam int DLY = 0;
    localparam bit FILTER = 1'b0;
`endif

    typedef struct packed {
        logic       lk_set;
        logic       lk_clr;
        logic       err;
        logic       emit;
        logic [7:0] s;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pwm_sample_decoder_if #(.SAMPLE_W(8)) bus ();

    pwm_sample_decoder #(
        .SAMPLE_W(8),
        .LOCK_PERIODS(LP),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dec(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [7:0] obs[$];

    logic       e_locked = 1'b0;
    logic       e_err = 1'b0;
    logic       e_valid = 1'b0;
    logic [7:0] e_sample = 8'h00;

    bit  m_locked = 1'b0;
    bit  m_aligned = 1'b0;
    int  good = 0;
    ev_t evq[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(posedge clk) begin
        #1;
        chk("locked", int'(bus.locked), int'(e_locked));
        chk("err", int'(bus.err), int'(e_err));
        chk("sample_valid", int'(bus.sample_valid), int'(e_valid));
        chk("sample_out", int'(bus.sample_out), int'(e_sample));
        if (bus.sample_valid) begin
            n_valid++;
            obs.push_back(bus.sample_out);
        end
        if (bus.err) n_err++;
    end

    task automatic model_reset();
        evq.delete();
        e_locked = 1'b0;
        e_err = 1'b0;
        e_valid = 1'b0;
        e_sample = 8'h00;
        m_locked = 1'b0;
        m_aligned = 1'b0;
        good = 0;
    endtask

    task automatic do_tick(input logic lvl, input ev_t ev, input int extra);
        ev_t a;
        bus.pwm_in = lvl;
        @(negedge clk);
        @(negedge clk);
        bus.tick_en = 1'b1;
        evq.push_back(ev);
        if (evq.size() > DLY) begin
            a = evq.pop_front();
            if (a.lk_set) e_locked = 1'b1;
            if (a.lk_clr) e_locked = 1'b0;
            e_err = a.err;
            e_valid = a.emit;
            if (a.emit) e_sample = a.s;
        end
        @(negedge clk);
        bus.tick_en = 1'b0;
        e_err = 1'b0;
        e_valid = 1'b0;
        for (int i = 0; i < extra; i++) begin
            bus.pwm_in = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_sample_out", int'(bus.sample_out), 0);
        chk("rst_valid", int'(bus.sample_valid), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_period(input logic [7:0] s, input int glitch_c, input int stall_c, input int rst_c);
        ev_t  ev;
        logic lvl;
        int   extra;
        for (int c = 0; c < 256; c++) begin
            ev = '0;
            lvl = (c < int'(s));
            if (c == 0 && s != 8'h00 && !m_locked) begin
                if (!m_aligned) begin
                    m_aligned = 1'b1;
                    good = 0;
                end else begin
                    good++;
                    if (good == LP) begin
                        m_locked = 1'b1;
                        ev.lk_set = 1'b1;
                    end
                end
            end
            if (c == glitch_c) begin
                lvl = 1'b1;
                if (!FILTER) begin
                    if (m_locked) begin
                        ev.err = 1'b1;
                        ev.lk_clr = 1'b1;
                    end
                    m_locked = 1'b0;
                    m_aligned = 1'b0;
                end
            end
            if (c == 255 && m_locked) begin
                ev.emit = 1'b1;
                ev.s = s;
            end
            extra = (c == stall_c) ? 50 : (($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
            do_tick(lvl, ev, extra);
            if (c == rst_c) reset_mid();
        end
    endtask

    function automatic logic [7:0] legal(input logic [7:0] s);
        if (FILTER && s == 8'h01) return 8'h02;
        if (FILTER && s == 8'hFF) return 8'hFE;
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int v0;
        int e0;
        logic [7:0] t3[4];
        bus.tick_en = 1'b0;
        bus.pwm_in = 1'b0;
        model_reset();

        // reset held with activity on the inputs
        rst_n = 1'b0;
        repeat (20) begin
            @(negedge clk);
            bus.pwm_in = 1'($urandom);
            bus.tick_en = 1'($urandom);
        end
        chk("hold_locked", int'(bus.locked), 0);
        chk("hold_valid", int'(bus.sample_valid), 0);
        chk("hold_sample", int'(bus.sample_out), 0);
        bus.tick_en = 1'b0;
        bus.pwm_in = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rel_locked", int'(bus.locked), 0);
        chk("rel_nvalid", n_valid, 0);

        // continuous 0x80: lock after LP+1 periods
        for (int p = 0; p < 4; p++) send_period(8'h80, -1, -1, -1);
        chk("pre_lock", int'(bus.locked), 0);
        send_period(8'h80, -1, -1, -1);
        chk("lock_0x80", int'(bus.locked), 1);
        chk("first_valids", n_valid, 1 - DLY);
        for (int p = 0; p < 4; p++) send_period(8'h80, -1, -1, -1);
        chk("valids_0x80", n_valid, 5 - DLY);
        chk("first_sample", int'(obs[0]), 8'h80);
        chk("no_err_0x80", n_err, 0);

        // boundary samples while locked
        if (FILTER) begin
            t3[0] = 8'h00; t3[1] = 8'hFE; t3[2] = 8'h02; t3[3] = 8'hFD;
        end else begin
            t3[0] = 8'h00; t3[1] = 8'hFF; t3[2] = 8'h01; t3[3] = 8'hFE;
        end
        for (int p = 0; p < 4; p++) send_period(t3[p], -1, -1, -1);
        send_period(8'h80, -1, -1, -1);
        chk("t3_locked", int'(bus.locked), 1);
        for (int p = 0; p < 4; p++)
            chk("t3_order", int'(obs[obs.size() - 5 + DLY + p]), int'(t3[p]));

        // glitch at phase 100 of a locked 0x40 stream
        e0 = n_err;
        send_period(8'h40, -1, -1, -1);
        send_period(8'h40, -1, -1, -1);
        send_period(8'h40, 100, -1, -1);
        chk("glitch_locked", int'(bus.locked), FILTER ? 1 : 0);
        chk("glitch_errs", n_err - e0, FILTER ? 0 : 1);
        for (int p = 0; p < 5; p++) send_period(8'h40, -1, -1, -1);
        chk("relock", int'(bus.locked), 1);

        // tick stall mid-period
        send_period(8'h55, -1, 128, -1);
        send_period(8'h33, -1, -1, -1);
        chk("stall_sample", int'(obs[obs.size() - 2 + DLY]), 8'h55);

        // random samples
        for (int p = 0; p < 8; p++) send_period(legal(8'($urandom_range(0, 255))), -1, -1, -1);
        chk("rand_locked", int'(bus.locked), 1);

        // reset at phase 130 of a locked stream, then relock
        send_period(8'h40, -1, -1, 130);
        chk("post_rst_locked", int'(bus.locked), 0);
        v0 = n_valid;
        for (int p = 0; p < 6; p++) send_period(8'h40, -1, -1, -1);
        send_period(8'h9A, -1, -1, -1);
        chk("rst_relock", int'(bus.locked), 1);
        chk("rst_valids", n_valid - v0, 3 - DLY);
        chk("rst_last", int'(obs[obs.size() - 1]), FILTER ? 8'h40 : 8'h9A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
